nand_read_cmd_seq: RTL and testbench

Command/address sequencer for the NAND page-read path: on a start request it drives the 00h command latch, column/row address latches and 30h confirm onto the flash bus, waits out tWB and the R/B busy period, then hands the bus to the downstream read-data stage by raising `read_start`. It sits between the host-side controller and the read-data stage and owns CE/CLE/ALE/WE and the I/O output driver for the setup phase.

---
 rtl/nand_read_cmd_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_nand_read_cmd_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/nand_read_cmd_seq.sv
// NAND page-read command/address sequencer: 00h, column/row address bytes, 30h, tWB, R/B wait, handoff.
// Optional busy timeout when NAND_BUSY_TIMEOUT_EN is defined; otherwise error stays 0.
module nand_read_cmd_seq #(
  parameter int ADDR_CYCLES    = 5,
  parameter int TWB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] col_addr,
  input  logic [23:0] row_addr,
  input  logic        RB,
  input  logic        read_complete,
  output logic        CE,
  output logic        CLE,
  output logic        ALE,
  output logic        WE,
  output logic [7:0]  io_out,
  output logic        io_oe,
  output logic        read_start,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD1, S_ADDR, S_CMD2, S_TWB, S_WAIT_RB, S_HANDOFF
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(ADDR_CYCLES - 1);
  localparam logic [7:0] TWB_LAST = 8'(TWB_CYCLES - 1);

  state_t      state_q, state_d;
  logic        phase_q, phase_d;   // 0 = phase A (WE low), 1 = phase B (WE high)
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  twb_q, twb_d;
  logic [15:0] col_q, col_d;
  logic [23:0] row_q, row_d;
  logic        err_q, err_d;
  logic [7:0]  addr_byte;
  logic        tmo_hit;

  // Registered bus/status outputs, computed from the current state
  logic       ce_q, ce_d;
  logic       cle_q, cle_d;
  logic       ale_q, ale_d;
  logic       we_q, we_d;
  logic [7:0] io_q, io_d;
  logic       oe_q, oe_d;
  logic       rs_q, rs_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;

`ifdef NAND_BUSY_TIMEOUT_EN
  logic [15:0] tmo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (state_q == S_WAIT_RB && !RB) begin
      tmo_q <= tmo_q + 16'd1;
    end else begin
      tmo_q <= '0;
    end
  end

  assign tmo_hit = (tmo_q == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    case (idx_q)
      3'd0:    addr_byte = col_q[7:0];
      3'd1:    addr_byte = col_q[15:8];
      3'd2:    addr_byte = row_q[7:0];
      3'd3:    addr_byte = row_q[15:8];
      default: addr_byte = row_q[23:16];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      idx_q   <= '0;
      twb_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
      ce_q    <= 1'b1;
      cle_q   <= 1'b0;
      ale_q   <= 1'b0;
      we_q    <= 1'b1;
      io_q    <= '0;
      oe_q    <= 1'b0;
      rs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      twb_q   <= twb_d;
      col_q   <= col_d;
      row_q   <= row_d;
      err_q   <= err_d;
      ce_q    <= ce_d;
      cle_q   <= cle_d;
      ale_q   <= ale_d;
      we_q    <= we_d;
      io_q    <= io_d;
      oe_q    <= oe_d;
      rs_q    <= rs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    twb_d   = twb_q;
    col_d   = col_q;
    row_d   = row_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CMD1;
          phase_d = 1'b0;
          col_d   = col_addr;
          row_d   = row_addr;
          err_d   = 1'b0;
        end
      end
      S_CMD1: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          state_d = S_ADDR;
          idx_d   = '0;
        end
      end
      S_ADDR: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (idx_q == LAST_IDX) state_d = S_CMD2;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      S_CMD2: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          state_d = S_TWB;
          twb_d   = '0;
        end
      end
      S_TWB: begin
        if (twb_q == TWB_LAST) state_d = S_WAIT_RB;
        else                   twb_d   = twb_q + 8'd1;
      end
      S_WAIT_RB: begin
        if (RB) begin
          state_d = S_HANDOFF;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_HANDOFF: begin
        if (read_complete) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs follow the state one clock later so every output is a flop
    ce_d    = 1'b1;
    cle_d   = 1'b0;
    ale_d   = 1'b0;
    we_d    = 1'b1;
    io_d    = 8'h00;
    oe_d    = 1'b0;
    rs_d    = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    error_d = err_q;

    case (state_q)
      S_IDLE: busy_d = 1'b0;
      S_CMD1: begin
        ce_d  = 1'b0;
        cle_d = 1'b1;
        we_d  = phase_q;
        oe_d  = 1'b1;
        io_d  = 8'h00;
      end
      S_ADDR: begin
        ce_d  = 1'b0;
        ale_d = 1'b1;
        we_d  = phase_q;
        oe_d  = 1'b1;
        io_d  = addr_byte;
      end
      S_CMD2: begin
        ce_d  = 1'b0;
        cle_d = 1'b1;
        we_d  = phase_q;
        oe_d  = 1'b1;
        io_d  = 8'h30;
      end
      S_TWB, S_WAIT_RB: ce_d = 1'b0;
      S_HANDOFF: begin
        ce_d   = 1'b0;
        rs_d   = 1'b1;
        done_d = ~rs_q;
      end
      default: busy_d = 1'b0;
    endcase
  end

  assign CE         = ce_q;
  assign CLE        = cle_q;
  assign ALE        = ale_q;
  assign WE         = we_q;
  assign io_out     = io_q;
  assign io_oe      = oe_q;
  assign read_start = rs_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_nand_read_cmd_seq.sv
// Directed bench for nand_read_cmd_seq: 5-byte and 4-byte address variants side by side.
module tb_nand_read_cmd_seq;

  logic        clk = 1'b0;
  logic        rst, start, RB, RB4, read_complete;
  logic [15:0] col_addr;
  logic [23:0] row_addr;

  logic       CE, CLE, ALE, WE, io_oe, read_start, busy, done, error;
  logic [7:0] io_out;
  logic       CE_4, CLE_4, ALE_4, WE_4, io_oe_4, read_start_4, busy_4, done_4, error_4;
  logic [7:0] io_out_4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nand_read_cmd_seq #(.ADDR_CYCLES(5), .TWB_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .start(start), .col_addr(col_addr), .row_addr(row_addr),
    .RB(RB), .read_complete(read_complete),
    .CE(CE), .CLE(CLE), .ALE(ALE), .WE(WE), .io_out(io_out), .io_oe(io_oe),
    .read_start(read_start), .busy(busy), .done(done), .error(error)
  );

  nand_read_cmd_seq #(.ADDR_CYCLES(4), .TWB_CYCLES(4), .TIMEOUT_CYCLES(100)) dut4 (
    .clk(clk), .rst(rst), .start(start), .col_addr(col_addr), .row_addr(row_addr),
    .RB(RB4), .read_complete(read_complete),
    .CE(CE_4), .CLE(CLE_4), .ALE(ALE_4), .WE(WE_4), .io_out(io_out_4), .io_oe(io_oe_4),
    .read_start(read_start_4), .busy(busy_4), .done(done_4), .error(error_4)
  );

  // Byte log captured at each WE falling transition: {CLE, ALE, io_out}
  logic [9:0] log5[$];
  logic [9:0] log4[$];
  logic       we5_prev = 1'b1;
  logic       we4_prev = 1'b1;

  always @(negedge clk) begin
    if (we5_prev && !WE) log5.push_back({CLE, ALE, io_out});
    if (we4_prev && !WE_4) log4.push_back({CLE_4, ALE_4, io_out_4});
    we5_prev = WE;
    we4_prev = WE_4;
  end

  logic [9:0] exp5[$] = '{10'h200, 10'h134, 10'h112, 10'h19A, 10'h178, 10'h156, 10'h230};
  logic [9:0] exp4[$] = '{10'h200, 10'h134, 10'h112, 10'h19A, 10'h178, 10'h230};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_log(input string tag, input logic [9:0] got[$], input logic [9:0] expq[$]);
    logic [9:0] g;
    chk({tag, "_count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      g = (i < got.size()) ? got[i] : 10'bx;
      chk($sformatf("%s[%0d]", tag, i), {22'd0, g}, {22'd0, expq[i]});
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench 1ns after the edge that accepts start (relative cycle 0)
  task automatic go();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; RB = 1'b0; RB4 = 1'b1; read_complete = 1'b0;
    col_addr = 16'h1234; row_addr = 24'h56789A;
    step(2);
    chk("rst_bus", {CE, CLE, ALE, WE, io_oe}, 5'b10010);
    chk("rst_io", io_out, 8'h00);
    chk("rst_status", {read_start, busy, done, error}, 4'b0000);
    rst = 1'b0;
    step(1);

    // Basic read, 10 busy clocks
    log5.delete(); log4.delete();
    go();
    step(1);
    chk("cmd1_bus", {CE, CLE, ALE, WE, io_oe, busy}, 6'b010011);
    chk("cmd1_io", io_out, 8'h00);
    step(6);
    chk("addr3_bus", {CLE, ALE, WE}, 3'b010);
    chk("addr3_io", io_out, 8'h9A);
    step(21);
    chk("waitrb_c28", {CE, io_oe, read_start, busy}, 4'b0001);
    RB = 1'b1;
    step(1);
    chk("rs_c29", read_start, 1'b0);
    step(1);
    chk("rs_done_c30", {read_start, done}, 2'b11);
    step(1);
    chk("rs_done_c31", {read_start, done}, 2'b10);
    chk_log("bytes5", log5, exp5);
    chk_log("bytes4", log4, exp4);
    chk("rs4_held", read_start_4, 1'b1);

    // Finish handoff, then restart on the very next cycle
    read_complete = 1'b1;
    step(1);
    read_complete = 1'b0;
    chk("rc_c32_rs", read_start, 1'b1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("rc_next_bus", {CE, busy, read_start}, 3'b100);
    chk("rc_next_bus4", {CE_4, busy_4, read_start_4}, 3'b100);

    // Stray read_complete at 5 and start at 8 are ignored; RB high throughout
    log5.delete(); log4.delete();
    step(4);
    read_complete = 1'b1;
    step(1);
    read_complete = 1'b0;
    step(2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("ign_c8", {ALE, WE, io_out}, 10'h39A);
    step(6);
    chk("cmd2b_c14", {CLE, WE, io_oe, io_out}, 11'h730);
    for (int c = 15; c <= 18; c++) begin
      step(1);
      chk($sformatf("twb_c%0d", c), {CE, CLE, WE, io_oe, read_start}, 5'b00100);
    end
    step(1);
    chk("rs_c19", read_start, 1'b0);
    step(1);
    chk("rs_done_c20", {read_start, done}, 2'b11);
    chk_log("ign_bytes5", log5, exp5);
    chk_log("ign_bytes4", log4, exp4);
    read_complete = 1'b1;
    step(1);
    read_complete = 1'b0;
    step(1);
    chk("rc_done_bus", {CE, busy, read_start}, 3'b100);

    // Async reset during ADDR byte 3 phase A
    go();
    step(7);
    chk("pre_rst_c7", {ALE, WE, io_out}, 10'h29A);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_bus", {CE, WE, io_oe, ALE, busy}, 5'b11000);
    step(1);
    rst = 1'b0;
    log5.delete(); log4.delete();
    go();
    step(20);
    chk("post_rst_rs", {read_start, done}, 2'b11);
    chk_log("post_rst_bytes5", log5, exp5);
    read_complete = 1'b1;
    step(1);
    read_complete = 1'b0;
    step(1);
    chk("post_rst_idle", {CE, busy}, 2'b10);

`ifdef NAND_BUSY_TIMEOUT_EN
    // RB stuck low: timeout after 100 WAIT_RB clocks
    RB = 1'b0;
    go();
    step(118);
    chk("tmo_c118", {error, busy, CE}, 3'b010);
    step(1);
    chk("tmo_c119", {error, busy, CE, io_oe, read_start, done}, 6'b101000);
    RB = 1'b1;
    go();
    step(1);
    chk("tmo_cleared", {error, busy}, 2'b01);
    step(19);
    chk("tmo_next_rs", read_start, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
